// File: rtl/pipe_addsub_if.sv
// Handshake and datapath bundle for pipe_addsub: operand beat in, result beat out.
interface pipe_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CI;
    logic             Sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] S;
    logic             CO;
    logic             OV;

    modport master (
        output in_valid, A, B, CI, Sub, out_ready,
        input  in_ready, out_valid, S, CO, OV
    );

    modport slave (
        input  in_valid, A, B, CI, Sub, out_ready,
        output in_ready, out_valid, S, CO, OV
    );
endinterface

// File: rtl/pipe_addsub.sv
// Pipelined adder/subtractor: carry ripples one WIDTH/STAGES chunk per stage,
// with a single global stall so the whole pipe holds while the result is refused.
module pipe_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input logic          Clock,
    input logic          Reset,
    pipe_addsub_if.slave bus
);
    localparam int CW = WIDTH / STAGES;
    localparam int L  = STAGES - 1;

    logic advance_s;
    logic ov_q;

    assign advance_s    = !g_stage[L].v_q || bus.out_ready;
    assign bus.in_ready = advance_s && !Reset;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * CW;
        localparam int NX = (k + 1) * CW;

        // Operand bits below LO are already consumed, so each stage only sees the upper part.
        logic [WIDTH-1:LO] a_in_s;
        logic [WIDTH-1:LO] b_in_s;
        logic              c_in_s;
        logic              v_in_s;
        logic [CW:0]       sum_s;
        logic [NX-1:0]     s_d;
        logic [NX-1:0]     s_q;
        logic              c_q;
        logic              v_q;

        if (k == 0) begin : g_in
            assign a_in_s = bus.A;
            assign b_in_s = bus.Sub ? ~bus.B : bus.B;
            assign c_in_s = bus.Sub ? ~bus.CI : bus.CI;
            assign v_in_s = bus.in_valid;
            assign s_d    = sum_s[CW-1:0];
        end else begin : g_in
            assign a_in_s = g_stage[k-1].g_fwd.a_q;
            assign b_in_s = g_stage[k-1].g_fwd.b_q;
            assign c_in_s = g_stage[k-1].c_q;
            assign v_in_s = g_stage[k-1].v_q;
            assign s_d    = {sum_s[CW-1:0], g_stage[k-1].s_q};
        end

        assign sum_s = {1'b0, a_in_s[LO +: CW]} + {1'b0, b_in_s[LO +: CW]} + {{CW{1'b0}}, c_in_s};

        // Stage register: partial sum, chunk carry and valid, held on stall.
        always_ff @(posedge Clock) begin
            if (Reset) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (advance_s) begin
                s_q <= s_d;
                c_q <= sum_s[CW];
                v_q <= v_in_s;
            end else begin
                s_q <= s_q;
                c_q <= c_q;
                v_q <= v_q;
            end
        end

        if (k < L) begin : g_fwd
            logic [WIDTH-1:NX] a_q;
            logic [WIDTH-1:NX] b_q;

            // Skew the not-yet-added operand chunks forward alongside the partial sum.
            always_ff @(posedge Clock) begin
                if (Reset) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance_s) begin
                    a_q <= a_in_s[WIDTH-1:NX];
                    b_q <= b_in_s[WIDTH-1:NX];
                end else begin
                    a_q <= a_q;
                    b_q <= b_q;
                end
            end
        end
    end

    // Overflow is resolved in the stage that adds the top chunk, where the sign bits still live.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            ov_q <= 1'b0;
        end else if (advance_s) begin
            ov_q <= (g_stage[L].a_in_s[WIDTH-1] == g_stage[L].b_in_s[WIDTH-1])
                 && (g_stage[L].s_d[WIDTH-1] != g_stage[L].a_in_s[WIDTH-1]);
        end else begin
            ov_q <= ov_q;
        end
    end

    assign bus.S         = g_stage[L].s_q;
    assign bus.CO        = g_stage[L].c_q;
    assign bus.OV        = ov_q;
    assign bus.out_valid = g_stage[L].v_q;
endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and randomised checks of pipe_addsub across four WIDTH/STAGES configurations.
module tb_pipe_addsub;
    logic clk;
    logic rst;

    logic [63:0] a_v [4];
    logic [63:0] b_v [4];
    logic        ci_v [4];
    logic        sub_v [4];
    logic        iv_v [4];
    logic        ordy_v [4];
    logic [63:0] s_v [4];
    logic        co_v [4];
    logic        ov_v [4];
    logic        ovld_v [4];
    logic        irdy_v [4];

    int          w_c [4] = '{32, 16, 64, 8};
    logic [65:0] expq [4][$];
    int          sent_n [4];
    int          got_n [4];
    bit          acc_f [4];
    int          n_vec = 0;
    int          n_err = 0;

    pipe_addsub_if #(.WIDTH(32)) if0 ();
    pipe_addsub_if #(.WIDTH(16)) if1 ();
    pipe_addsub_if #(.WIDTH(64)) if2 ();
    pipe_addsub_if #(.WIDTH(8))  if3 ();

    pipe_addsub #(.WIDTH(32), .STAGES(4)) dut0 (.Clock(clk), .Reset(rst), .bus(if0.slave));
    pipe_addsub #(.WIDTH(16), .STAGES(1)) dut1 (.Clock(clk), .Reset(rst), .bus(if1.slave));
    pipe_addsub #(.WIDTH(64), .STAGES(8)) dut2 (.Clock(clk), .Reset(rst), .bus(if2.slave));
    pipe_addsub #(.WIDTH(8),  .STAGES(8)) dut3 (.Clock(clk), .Reset(rst), .bus(if3.slave));

    assign if0.in_valid = iv_v[0];   assign if0.out_ready = ordy_v[0];
    assign if0.A = a_v[0][31:0];     assign if0.B = b_v[0][31:0];
    assign if0.CI = ci_v[0];         assign if0.Sub = sub_v[0];
    assign s_v[0] = {32'd0, if0.S};  assign co_v[0] = if0.CO;  assign ov_v[0] = if0.OV;
    assign ovld_v[0] = if0.out_valid; assign irdy_v[0] = if0.in_ready;

    assign if1.in_valid = iv_v[1];   assign if1.out_ready = ordy_v[1];
    assign if1.A = a_v[1][15:0];     assign if1.B = b_v[1][15:0];
    assign if1.CI = ci_v[1];         assign if1.Sub = sub_v[1];
    assign s_v[1] = {48'd0, if1.S};  assign co_v[1] = if1.CO;  assign ov_v[1] = if1.OV;
    assign ovld_v[1] = if1.out_valid; assign irdy_v[1] = if1.in_ready;

    assign if2.in_valid = iv_v[2];   assign if2.out_ready = ordy_v[2];
    assign if2.A = a_v[2];           assign if2.B = b_v[2];
    assign if2.CI = ci_v[2];         assign if2.Sub = sub_v[2];
    assign s_v[2] = if2.S;           assign co_v[2] = if2.CO;  assign ov_v[2] = if2.OV;
    assign ovld_v[2] = if2.out_valid; assign irdy_v[2] = if2.in_ready;

    assign if3.in_valid = iv_v[3];   assign if3.out_ready = ordy_v[3];
    assign if3.A = a_v[3][7:0];      assign if3.B = b_v[3][7:0];
    assign if3.CI = ci_v[3];         assign if3.Sub = sub_v[3];
    assign s_v[3] = {56'd0, if3.S};  assign co_v[3] = if3.CO;  assign ov_v[3] = if3.OV;
    assign ovld_v[3] = if3.out_valid; assign irdy_v[3] = if3.in_ready;

    // Free-running clock.
    always #5 clk = ~clk;

    function automatic logic [63:0] mask_of(input int w);
        logic [63:0] one;
        one = 64'd1;
        return (w == 64) ? {64{1'b1}} : ((one << w) - 64'd1);
    endfunction

    // Reference: returns {CO, OV, S} computed at full precision.
    function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic ci, input logic sub, input int w);
        logic [64:0] full;
        logic [63:0] m;
        logic [63:0] am;
        logic [63:0] bp;
        logic [63:0] s;
        logic        c;
        logic        ov;
        m    = mask_of(w);
        am   = a & m;
        bp   = (sub ? ~b : b) & m;
        c    = sub ? ~ci : ci;
        full = {1'b0, am} + {1'b0, bp} + {64'd0, c};
        s    = full[63:0] & m;
        ov   = (am[w-1] == bp[w-1]) && (s[w-1] != am[w-1]);
        return {full[w], ov, s};
    endfunction

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_beat(input int i);
        a_v[i]   = {$urandom, $urandom} & mask_of(w_c[i]);
        b_v[i]   = {$urandom, $urandom} & mask_of(w_c[i]);
        ci_v[i]  = 1'($urandom_range(0, 1));
        sub_v[i] = 1'($urandom_range(0, 1));
    endtask

    // Scoreboard all instances for the current cycle, then advance one clock.
    task automatic step();
        logic [65:0] e;
        for (int i = 0; i < 4; i++) begin
            acc_f[i] = iv_v[i] && irdy_v[i];
            if (ovld_v[i] && ordy_v[i]) begin
                if (expq[i].size() == 0) begin
                    check($sformatf("spurious_out[%0d]", i), {65'd0, ovld_v[i]}, 66'd0);
                end else begin
                    e = expq[i].pop_front();
                    check($sformatf("sb_s[%0d]", i),  {2'b00, s_v[i]}, {2'b00, e[63:0]});
                    check($sformatf("sb_co[%0d]", i), {65'd0, co_v[i]}, {65'd0, e[65]});
                    check($sformatf("sb_ov[%0d]", i), {65'd0, ov_v[i]}, {65'd0, e[64]});
                    got_n[i]++;
                end
            end
            if (acc_f[i]) expq[i].push_back(model(a_v[i], b_v[i], ci_v[i], sub_v[i], w_c[i]));
        end
        tick();
    endtask

    task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic ci, input logic sub,
                            input logic [31:0] es, input logic eco, input logic eov);
        a_v[0] = {32'd0, a}; b_v[0] = {32'd0, b}; ci_v[0] = ci; sub_v[0] = sub;
        iv_v[0] = 1'b1;
        check({tag, "_rdy"}, {65'd0, irdy_v[0]}, 66'd1);
        tick();
        iv_v[0] = 1'b0;
        tick();
        tick();
        check({tag, "_early"}, {65'd0, ovld_v[0]}, 66'd0);
        tick();
        check({tag, "_vld"}, {65'd0, ovld_v[0]}, 66'd1);
        check({tag, "_s"},   {2'b00, s_v[0]}, {34'd0, es});
        check({tag, "_co"},  {65'd0, co_v[0]}, {65'd0, eco});
        check({tag, "_ov"},  {65'd0, ov_v[0]}, {65'd0, eov});
    endtask

    initial begin
        int  sent;
        int  stall_left;
        bit  done;
        clk = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a_v[i] = 64'd0; b_v[i] = 64'd0; ci_v[i] = 1'b0; sub_v[i] = 1'b0;
            iv_v[i] = 1'b0; ordy_v[i] = 1'b1; sent_n[i] = 0; got_n[i] = 0; acc_f[i] = 1'b0;
        end
        tick();
        tick();
        check("rst_in_ready", {65'd0, irdy_v[0]}, 66'd0);
        check("rst_out_valid", {65'd0, ovld_v[0]}, 66'd0);
        check("rst_s", {2'b00, s_v[0]}, 66'd0);
        check("rst_co", {65'd0, co_v[0]}, 66'd0);
        check("rst_ov", {65'd0, ov_v[0]}, 66'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", {65'd0, irdy_v[0]}, 66'd1);

        directed("add_ripple", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_borrow", 32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_nobrw",  32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0001, 1'b1, 1'b0);
        directed("add_ovf",    32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("add_plain",  32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0);
        tick();

        // Backpressure: 8 back-to-back beats, 3-cycle stall after the first result.
        sent = 0;
        stall_left = -1;
        got_n[0] = 0;
        new_beat(0);
        for (int cyc = 0; cyc < 40 && got_n[0] < 8; cyc++) begin
            iv_v[0]   = (sent < 8);
            ordy_v[0] = !(stall_left > 0);
            #1;
            if (stall_left > 0) begin
                check("bp_in_ready", {65'd0, irdy_v[0]}, 66'd0);
                check("bp_vld", {65'd0, ovld_v[0]}, 66'd1);
                check("bp_hold_s", {2'b00, s_v[0]}, {2'b00, expq[0][0][63:0]});
                stall_left--;
            end
            step();
            if (acc_f[0]) begin
                sent++;
                new_beat(0);
            end
            if (stall_left < 0 && got_n[0] >= 1) stall_left = 3;
        end
        check("bp_count", 66'(got_n[0]), 66'd8);
        iv_v[0] = 1'b0;
        ordy_v[0] = 1'b1;

        // Reset with three beats in flight.
        for (int j = 0; j < 3; j++) begin
            new_beat(0);
            iv_v[0] = 1'b1;
            #1;
            step();
        end
        iv_v[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", {65'd0, irdy_v[0]}, 66'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) expq[i].delete();
        check("mid_rst_vld", {65'd0, ovld_v[0]}, 66'd0);
        check("mid_rst_s", {2'b00, s_v[0]}, 66'd0);
        check("mid_rst_co", {65'd0, co_v[0]}, 66'd0);
        check("mid_rst_ov", {65'd0, ov_v[0]}, 66'd0);
        for (int j = 0; j < 6; j++) begin
            #1;
            check("mid_rst_no_stale", {65'd0, ovld_v[0]}, 66'd0);
            step();
        end

        // Random sweep over all four configurations at once.
        for (int i = 0; i < 4; i++) begin
            sent_n[i] = 0;
            got_n[i] = 0;
        end
        for (int cyc = 0; cyc < 6000; cyc++) begin
            done = 1'b1;
            for (int i = 0; i < 4; i++)
                if (sent_n[i] < 256 || expq[i].size() != 0) done = 1'b0;
            if (done) break;
            for (int i = 0; i < 4; i++) begin
                iv_v[i]   = (sent_n[i] < 256) && ($urandom_range(0, 3) != 0);
                ordy_v[i] = ($urandom_range(0, 3) != 0);
                new_beat(i);
            end
            #1;
            step();
            for (int i = 0; i < 4; i++)
                if (acc_f[i]) sent_n[i]++;
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("sweep_sent[%0d]", i), 66'(sent_n[i]), 66'd256);
            check($sformatf("sweep_got[%0d]", i), 66'(got_n[i]), 66'd256);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
